// File: rtl/stream_arb_pkg.sv
// Shared types and defaults for the round-robin stream arbiter.
// Packet locking is compiled in with STREAM_ARB_PKT_LOCK_EN.
package stream_arb_pkg;

  localparam int N_REQ_DEF  = 4;
  localparam int DATA_W_DEF = 256;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or after
// last_winner+1 (wrapping) with its request bit set.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int GNT_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [GNT_W-1:0] last_winner,
  output logic [N_REQ-1:0] gnt,
  output logic [GNT_W-1:0] gnt_idx,
  output logic             any_req
);

  always_comb begin
    int idx;
    idx     = 0;
    gnt     = '0;
    gnt_idx = '0;
    any_req = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last_winner) + k) % N_REQ;
      if (!any_req && req[idx]) begin
        any_req  = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = GNT_W'(idx);
      end
    end
  end

endmodule

// File: rtl/stream_rr_arb.sv
// N-to-1 round-robin stream arbiter with a single forward register stage.
// Define STREAM_ARB_PKT_LOCK_EN to hold the grant for a whole packet.
module stream_rr_arb
  import stream_arb_pkg::*;
#(
  parameter int N_REQ  = N_REQ_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int GNT_W  = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        f_valid_in,
  input  logic [N_REQ*DATA_W-1:0] f_data_in,
  input  logic [N_REQ-1:0]        f_last_in,
  output logic [N_REQ-1:0]        f_ready_out,
  output logic                    b_valid_out,
  output logic [DATA_W-1:0]       b_data_out,
  output logic                    b_last_out,
  output logic [GNT_W-1:0]        b_gnt_out,
  input  logic                    b_ready_in
);

  logic              load_en;
  logic              accept;
  logic [GNT_W-1:0]  last_winner;
  logic [N_REQ-1:0]  pick_gnt;
  logic [GNT_W-1:0]  pick_idx;
  logic              pick_any;
  logic [N_REQ-1:0]  gnt_vec;
  logic [GNT_W-1:0]  sel_idx;
  logic              sel_last;
  logic [DATA_W-1:0] sel_data;
  logic              lw_update;

  rr_pick #(
    .N_REQ (N_REQ),
    .GNT_W (GNT_W)
  ) u_pick (
    .req         (f_valid_in),
    .last_winner (last_winner),
    .gnt         (pick_gnt),
    .gnt_idx     (pick_idx),
    .any_req     (pick_any)
  );

  assign load_en     = !b_valid_out || b_ready_in;
  assign f_ready_out = (!rst && load_en) ? gnt_vec : '0;
  assign accept      = |(f_valid_in & f_ready_out);
  assign sel_last    = f_last_in[sel_idx];
  assign sel_data    = f_data_in[int'(sel_idx)*DATA_W +: DATA_W];

`ifdef STREAM_ARB_PKT_LOCK_EN
  arb_state_t       state;
  arb_state_t       state_nxt;
  logic [GNT_W-1:0] lock_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ARB_IDLE;
      lock_idx <= '0;
    end else begin
      state <= state_nxt;
      if (state == ARB_IDLE && accept && !sel_last)
        lock_idx <= sel_idx;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE: if (accept && !sel_last) state_nxt = ARB_LOCK;
      ARB_LOCK: if (accept && sel_last)  state_nxt = ARB_IDLE;
      default:  state_nxt = ARB_IDLE;
    endcase
  end

  // While locked the grant is pinned even if the owner drops valid (stall).
  always_comb begin
    gnt_vec = '0;
    sel_idx = '0;
    if (state == ARB_LOCK) begin
      gnt_vec = {{(N_REQ-1){1'b0}}, 1'b1} << lock_idx;
      sel_idx = lock_idx;
    end else begin
      gnt_vec = pick_any ? pick_gnt : '0;
      sel_idx = pick_idx;
    end
  end

  assign lw_update = accept && sel_last;
`else
  assign gnt_vec   = pick_any ? pick_gnt : '0;
  assign sel_idx   = pick_idx;
  assign lw_update = accept;
`endif

  always_ff @(posedge clk) begin
    if (rst)
      last_winner <= GNT_W'(N_REQ - 1);
    else if (lw_update)
      last_winner <= sel_idx;
  end

  // Output stage refills whenever it is empty or being drained this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      b_valid_out <= 1'b0;
      b_data_out  <= '0;
      b_last_out  <= 1'b0;
      b_gnt_out   <= '0;
    end else if (load_en) begin
      b_valid_out <= accept;
      if (accept) begin
        b_data_out <= sel_data;
        b_last_out <= sel_last;
        b_gnt_out  <= sel_idx;
      end
    end
  end

endmodule

// File: doc/stream_rr_arb.md
STREAM_RR_ARB -- requirements
Module: stream_rr_arb

Interface
REQ-001 The block SHALL have these parameters, one per line (name, default, meaning):
- N_REQ, 4, number of requesters, 2..16.
- DATA_W, 256, payload width.
- GNT_W, $clog2(N_REQ), grant index width.

REQ-002 The block SHALL have these ports, clock and reset first (name, direction, width, meaning):
- clk, input, 1, single clock; all logic is rising-edge.
- rst, input, 1, synchronous, active-high reset.
- f_valid_in, input, N_REQ, per-requester valid.
- f_data_in, input, N_REQ*DATA_W, requester i occupies bits [i*DATA_W +: DATA_W].
- f_last_in, input, N_REQ, last beat of packet, per requester.
- f_ready_out, output, N_REQ, per-requester ready.
- b_valid_out, output, 1, output valid.
- b_data_out, output, DATA_W, output payload.
- b_last_out, output, 1, output last.
- b_gnt_out, output, GNT_W, index of the requester that sourced the current output beat.
- b_ready_in, input, 1, downstream ready.

REQ-003 Clock and reset SHALL be exactly as decided: one clock (clk); reset (rst) synchronous and active-high.

Function
REQ-004 The output SHALL be a single register stage, fwd-style. It SHALL load when load_en = !b_valid_out || b_ready_in. Latency is 1 cycle from input handshake to b_valid_out. Full throughput: 1 beat/cycle with b_ready_in held high.

REQ-005 A transfer on requester i SHALL occur only when f_valid_in[i] && f_ready_out[i].

REQ-006 f_ready_out[i] SHALL be high only when i is granted and load_en is high. At most one bit of f_ready_out SHALL be high in any cycle.

REQ-007 Arbitration SHALL be round-robin. The search starts at index (last_winner+1) mod N_REQ and picks the first requester with valid set. last_winner resets to N_REQ-1, so requester 0 has first priority after reset.

REQ-008 The FSM SHALL have two states:
- IDLE: arbitrate each cycle.
- LOCK: grant is held on the locked index.

REQ-009 IDLE->LOCK SHALL occur when a beat is accepted with f_last_in=0. LOCK->IDLE SHALL occur when the locked requester's beat is accepted with f_last_in=1. A single-beat packet (last=1) stays in IDLE.

REQ-010 In LOCK, other requesters' valids SHALL be ignored. If the locked requester deasserts valid, the block SHALL stall and the grant SHALL NOT move.

REQ-011 last_winner SHALL update only on acceptance of a beat with f_last_in=1.

REQ-012 b_data_out, b_last_out and b_gnt_out SHALL hold stable while b_valid_out=1 and b_ready_in=0.

REQ-013 Simultaneous output drain and new load SHALL occur in the same cycle with no bubble.

REQ-014 If no valid input is present when load_en is high, b_valid_out SHALL go to 0 on the next edge.

Reset
REQ-015 On rst=1 at a clock edge the block SHALL set:
- b_valid_out=0, b_last_out=0, b_data_out=0, b_gnt_out=0;
- FSM=IDLE;
- last_winner=N_REQ-1.

REQ-016 While rst=1, f_ready_out SHALL be all-zero.

REQ-017 Reset mid-packet SHALL drop both the lock and the output beat. No partial state SHALL survive reset.

Configuration
REQ-018 With macro STREAM_ARB_PKT_LOCK_EN defined, REQ-008 to REQ-011 SHALL apply.

REQ-019 Without STREAM_ARB_PKT_LOCK_EN:
- the FSM SHALL be absent;
- arbitration SHALL occur on every beat;
- last_winner SHALL update on every accepted beat;
- f_last_in SHALL pass through to b_last_out without affecting grant.

Structure
REQ-020 A shared package stream_arb_pkg SHALL hold:
- the FSM state enum (ARB_IDLE, ARB_LOCK);
- the default N_REQ and DATA_W constants.

REQ-021 The round-robin pick SHALL be a combinational sub-module rr_pick. Inputs: req vector, last_winner. Outputs: one-hot grant, grant index, any_req.

REQ-022 The remaining logic SHALL live in stream_rr_arb: FSM, last_winner register, data mux and output register.

Verification
REQ-023 The bench SHALL cover these directed scenarios (stimulus -> required response):
- Basic order: after reset, all 4 requesters valid with single-beat packets, b_ready_in=1 -> b_gnt_out sequence 0,1,2,3,0 on consecutive cycles; first b_valid_out 1 cycle after first handshake.
- Packet lock (macro on): req1 sends a 3-beat packet (last on beat 3) while req2 is valid throughout -> outputs 1,1,1 then 2; f_ready_out[2]=0 during the lock.
- Lock stall: req1 mid-packet drops valid for 2 cycles while req0 is valid -> no output from req0; req1 resumes and finishes; req0 is granted next.
- Backpressure: b_ready_in=0 for 5 cycles with data 0xA5 loaded -> b_data_out=0xA5 stable; f_ready_out=0; the next beat appears on the cycle after b_ready_in=1.
- Reset mid-packet: rst=1 during beat 2 of a req3 packet -> next cycle b_valid_out=0 and FSM IDLE; req0 wins the next arbitration.
- Macro off: the same stimulus as the packet-lock scenario -> outputs interleave 1,2,1,2,1.
